// File: rtl/rmii_mii.sv
// ---------------------------------------------------------------------------
// RmiiMii -- RMII (MAC side) to MII (PHY-side block) bridge, 100 Mb/s only.
//
// Everything runs on the 50 MHz RMII reference clock. One MII nibble spans
// exactly two reference-clock cycles, so each nibble maps to two RMII dibits,
// low dibit first.
//
// Ports
//   rmii_refclk  in   1  sole clock, rising edge
//   rst_l        in   1  asynchronous active-low reset
//   rmii_txd     in   2  transmit dibit from the MAC
//   rmii_tx_en   in   1  transmit enable from the MAC
//   rmii_rxd     out  2  receive dibit to the MAC (registered)
//   rmii_crs_dv  out  1  carrier-sense/data-valid to the MAC (registered)
//   rmii_rx_er   out  1  receive error to the MAC (registered)
//   mii_rxclk    in   1  pin compatibility only, unused
//   mii_txclk    in   1  pin compatibility only, unused
//   mii_rxd      in   4  receive nibble from the PHY-side block
//   mii_rx_dv    in   1  receive data valid
//   mii_rx_er    in   1  receive error
//   mii_crs      in   1  carrier sense, ignored
//   mii_col      in   1  collision, ignored
//   mii_txd      out  4  transmit nibble to the PHY-side block (registered)
//   mii_tx_en    out  1  transmit enable (registered)
//   mii_tx_er    out  1  transmit error, tied low
// ---------------------------------------------------------------------------
module rmii_mii (
  input  logic       rmii_refclk,
  input  logic       rst_l,
  input  logic [1:0] rmii_txd,
  input  logic       rmii_tx_en,
  output logic [1:0] rmii_rxd,
  output logic       rmii_crs_dv,
  output logic       rmii_rx_er,
  input  logic       mii_rxclk,
  input  logic       mii_txclk,
  input  logic [3:0] mii_rxd,
  input  logic       mii_rx_dv,
  input  logic       mii_rx_er,
  input  logic       mii_crs,
  input  logic       mii_col,
  output logic [3:0] mii_txd,
  output logic       mii_tx_en,
  output logic       mii_tx_er
);

  // Which half of a nibble the current TX dibit belongs to.
  typedef enum logic {
    SLOT_LO = 1'b0,
    SLOT_HI = 1'b1
  } txSlotT;

  // Which half of the current RX nibble is being presented to the MAC.
  typedef enum logic {
    PH_LO = 1'b0,
    PH_HI = 1'b1
  } rxPhaseT;

  // TX path state
  txSlotT     r_sel;
  logic       r_hold;
  logic [1:0] r_txLo;
  logic [3:0] r_txNibble;
  logic       r_txEn;

  // RX path state
  rxPhaseT    r_ph;
  logic [1:0] r_rxHi;
  logic [1:0] r_rxDibit;
  logic       r_crsDv;
  logic       r_rxEr;

  // The MII clocks, carrier and collision exist only so the block drops
  // into an MII footprint; they are folded into a sink so nothing uses them.
  logic w_unused_pins;
  assign w_unused_pins = ^{mii_rxclk, mii_txclk, mii_crs, mii_col};

  // TX: pair up RMII dibits into MII nibbles. The slot bit restarts at the
  // low half whenever tx_en is low, so every frame is aligned to its first
  // dibit. A completed nibble sets 'hold' so that the following cycle keeps
  // the nibble on the bus even if tx_en has already dropped; that gives
  // every nibble a two-cycle lifetime and makes tx_en fall two cycles after
  // the last completed nibble. A lone trailing dibit is simply never paired,
  // so it never reaches the MII side.
  always_ff @(posedge rmii_refclk or negedge rst_l) begin
    if (!rst_l) begin
      r_sel      <= SLOT_LO;
      r_hold     <= 1'b0;
      r_txLo     <= 2'b00;
      r_txNibble <= 4'h0;
      r_txEn     <= 1'b0;
    end else if (rmii_tx_en && (r_sel == SLOT_HI)) begin
      r_txNibble <= {rmii_txd, r_txLo};
      r_txEn     <= 1'b1;
      r_hold     <= 1'b1;
      r_sel      <= SLOT_LO;
    end else begin
      r_hold <= 1'b0;
      if (rmii_tx_en) begin
        r_txLo <= rmii_txd;
        r_sel  <= SLOT_HI;
      end else begin
        r_sel  <= SLOT_LO;
      end
      if (!r_hold && !rmii_tx_en) begin
        r_txNibble <= 4'h0;
        r_txEn     <= 1'b0;
      end
    end
  end

  // RX: a free-running phase bit splits each MII nibble into two dibits.
  // The upstream block keeps its nibble stable across the low-phase edge,
  // which is where everything is captured; the high dibit is parked in
  // r_rxHi and presented on the next cycle, while valid and error simply
  // hold for both halves of the nibble.
  always_ff @(posedge rmii_refclk or negedge rst_l) begin
    if (!rst_l) begin
      r_ph      <= PH_LO;
      r_rxHi    <= 2'b00;
      r_rxDibit <= 2'b00;
      r_crsDv   <= 1'b0;
      r_rxEr    <= 1'b0;
    end else begin
      r_ph <= (r_ph == PH_LO) ? PH_HI : PH_LO;
      if (r_ph == PH_LO) begin
        r_rxDibit <= mii_rxd[1:0];
        r_rxHi    <= mii_rxd[3:2];
        r_crsDv   <= mii_rx_dv;
        r_rxEr    <= mii_rx_er;
      end else begin
        r_rxDibit <= r_rxHi;
      end
    end
  end

  assign mii_txd     = r_txNibble;
  assign mii_tx_en   = r_txEn;
  assign mii_tx_er   = 1'b0;

  assign rmii_rxd    = r_rxDibit;
  assign rmii_crs_dv = r_crsDv;
  assign rmii_rx_er  = r_rxEr;

endmodule

// File: tb/tb_rmii_mii.sv
// ---------------------------------------------------------------------------
// Self-checking bench for rmii_mii: a directed vector table, hand-written
// reset sequences, and a randomised concurrent TX/RX run checked against
// expectations computed from the nibble/dibit mapping rules.
// ---------------------------------------------------------------------------
module tb_rmii_mii;

  localparam int NC  = 140;  // cycles in the randomised run
  localparam int TXS = 3;    // edge on which the random TX frame starts
  localparam int RXS = 2;    // edge on which the random RX frame starts

  logic       clk;
  logic       rst_l;
  logic [1:0] rmii_txd;
  logic       rmii_tx_en;
  logic [1:0] rmii_rxd;
  logic       rmii_crs_dv;
  logic       rmii_rx_er;
  logic       mii_rxclk;
  logic       mii_txclk;
  logic [3:0] mii_rxd;
  logic       mii_rx_dv;
  logic       mii_rx_er;
  logic       mii_crs;
  logic       mii_col;
  logic [3:0] mii_txd;
  logic       mii_tx_en;
  logic       mii_tx_er;

  int checkCount = 0;
  int passCount  = 0;

  rmii_mii dut (
    .rmii_refclk (clk),
    .rst_l       (rst_l),
    .rmii_txd    (rmii_txd),
    .rmii_tx_en  (rmii_tx_en),
    .rmii_rxd    (rmii_rxd),
    .rmii_crs_dv (rmii_crs_dv),
    .rmii_rx_er  (rmii_rx_er),
    .mii_rxclk   (mii_rxclk),
    .mii_txclk   (mii_txclk),
    .mii_rxd     (mii_rxd),
    .mii_rx_dv   (mii_rx_dv),
    .mii_rx_er   (mii_rx_er),
    .mii_crs     (mii_crs),
    .mii_col     (mii_col),
    .mii_txd     (mii_txd),
    .mii_tx_en   (mii_tx_en),
    .mii_tx_er   (mii_tx_er)
  );

  // 50 MHz reference clock; the MII pin clocks just wiggle to prove they
  // have no effect.
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial begin
    mii_rxclk = 1'b0;
    mii_txclk = 1'b1;
    forever begin
      #7 mii_rxclk = ~mii_rxclk;
      mii_txclk = ~mii_txclk;
    end
  end

  // Guard against the run never reaching its summary.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct {
    logic       txEn;
    logic [1:0] txd;
    logic [3:0] rxd;
    logic       rxDv;
    logic       rxEr;
    logic [3:0] expTxd;
    logic       expTxEn;
    logic [1:0] expRxd;
    logic       expCrsDv;
    logic       expRxEr;
  } vecT;

  // All outputs packed as {mii_txd, mii_tx_en, mii_tx_er, rmii_rxd, crs_dv, rx_er}
  function automatic logic [9:0] outBus();
    return {mii_txd, mii_tx_en, mii_tx_er, rmii_rxd, rmii_crs_dv, rmii_rx_er};
  endfunction

  function automatic logic [9:0] packExp(logic [3:0] t, logic te, logic [1:0] r,
                                         logic dv, logic er);
    return {t, te, 1'b0, r, dv, er};
  endfunction

  // One rising edge, then come back to the falling edge to sample/drive.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic txEn, input logic [1:0] txd,
                               input logic [3:0] rxd, input logic rxDv,
                               input logic rxEr);
    rmii_tx_en = txEn;
    rmii_txd   = txd;
    mii_rxd    = rxd;
    mii_rx_dv  = rxDv;
    mii_rx_er  = rxEr;
  endtask

  task automatic checkOutput(input string name, input logic [9:0] act,
                             input logic [9:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got txd=%h txen=%b txer=%b rxd=%h crsdv=%b rxer=%b, wanted txd=%h txen=%b txer=%b rxd=%h crsdv=%b rxer=%b",
                  name, act[9:6], act[5], act[4], act[3:2], act[1], act[0],
                  exp[9:6], exp[5], exp[4], exp[3:2], exp[1], exp[0]);
  endtask

  // Reset for two edges, released on a falling edge so the next rising
  // edge is the first post-reset edge.
  task automatic resetDut();
    rst_l = 1'b0;
    tick();
    tick();
    rst_l = 1'b1;
  endtask

  vecT        vecs [12];
  logic [1:0] txDib    [129];
  logic [3:0] rxNib    [64];
  logic       rxErBit  [64];
  logic [3:0] expTxd   [NC];
  logic       expTxEn  [NC];
  logic [1:0] expRxd   [NC];
  logic       expCrsDv [NC];
  logic       expRxEr  [NC];
  int         txLen;

  initial begin
    // Directed vectors starting from the first edge after reset: a 4-dibit
    // TX frame alongside an RX nibble 0xB then an error nibble, followed by
    // an odd 3-dibit TX frame alongside RX nibble 0x6.
    vecs[0]  = '{1'b1, 2'd1, 4'hB, 1'b1, 1'b0, 4'h0, 1'b0, 2'd3, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 2'd2, 4'hB, 1'b1, 1'b0, 4'h9, 1'b1, 2'd2, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 2'd3, 4'h4, 1'b1, 1'b1, 4'h9, 1'b1, 2'd0, 1'b1, 1'b1};
    vecs[3]  = '{1'b1, 2'd0, 4'h4, 1'b1, 1'b1, 4'h3, 1'b1, 2'd1, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 4'h3, 1'b1, 2'd0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 2'd2, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 2'd1, 4'h6, 1'b1, 1'b0, 4'h6, 1'b1, 2'd2, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 2'd3, 4'h6, 1'b1, 1'b0, 4'h6, 1'b1, 2'd1, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0};

    rst_l   = 1'b0;
    mii_crs = 1'b0;
    mii_col = 1'b0;
    applyStimulus(1'b0, 2'd0, 4'h0, 1'b0, 1'b0);

    // Reset state before any clock edge has happened.
    #3;
    checkOutput("resetNoClock", outBus(), 10'h000);

    @(negedge clk);
    resetDut();
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].txEn, vecs[i].txd, vecs[i].rxd, vecs[i].rxDv, vecs[i].rxEr);
      mii_crs = i[0];
      mii_col = ~i[0];
      tick();
      checkOutput($sformatf("vec%0d", i), outBus(),
                  packExp(vecs[i].expTxd, vecs[i].expTxEn, vecs[i].expRxd,
                          vecs[i].expCrsDv, vecs[i].expRxEr));
    end

    // Reset dropped in the middle of a TX frame and an RX nibble: outputs
    // must clear without a clock, stay clear under reset, and after release
    // the first edge must sample the low dibit.
    applyStimulus(1'b1, 2'd1, 4'hF, 1'b1, 1'b1);
    tick();
    tick();
    tick();
    #3;
    rst_l = 1'b0;
    #1;
    checkOutput("asyncResetMidFrame", outBus(), 10'h000);
    tick();
    tick();
    checkOutput("heldInReset", outBus(), 10'h000);
    applyStimulus(1'b0, 2'd3, 4'h9, 1'b1, 1'b0);
    rst_l = 1'b1;
    tick();
    checkOutput("phRestartLow", outBus(), packExp(4'h0, 1'b0, 2'd1, 1'b1, 1'b0));
    tick();
    checkOutput("phRestartHigh", outBus(), packExp(4'h0, 1'b0, 2'd2, 1'b1, 1'b0));

    // Randomised concurrent 64-nibble frames. Expectations come from the
    // mapping rules: TX dibits 2k,2k+1 of a frame starting at edge S form
    // nibble {d[2k+1],d[2k]}, shown after edges S+2k+1 and S+2k+2; RX nibble
    // j held over edges RXS+2j and RXS+2j+1 appears as its low dibit then
    // its high dibit after those same edges.
    txLen = 128 + int'($urandom_range(0, 1));
    for (int k = 0; k < 129; k++) txDib[k] = 2'($urandom_range(0, 3));
    for (int j = 0; j < 64; j++) begin
      rxNib[j]   = 4'($urandom_range(0, 15));
      rxErBit[j] = ($urandom_range(0, 7) == 0);
    end
    for (int e = 0; e < NC; e++) begin
      expTxd[e]   = 4'h0;
      expTxEn[e]  = 1'b0;
      expRxd[e]   = 2'd0;
      expCrsDv[e] = 1'b0;
      expRxEr[e]  = 1'b0;
    end
    for (int k = 0; k < txLen / 2; k++) begin
      for (int c = TXS + 2 * k + 1; c <= TXS + 2 * k + 2; c++) begin
        expTxd[c]  = {txDib[2 * k + 1], txDib[2 * k]};
        expTxEn[c] = 1'b1;
      end
    end
    for (int j = 0; j < 64; j++) begin
      expRxd[RXS + 2 * j]       = rxNib[j][1:0];
      expRxd[RXS + 2 * j + 1]   = rxNib[j][3:2];
      expCrsDv[RXS + 2 * j]     = 1'b1;
      expCrsDv[RXS + 2 * j + 1] = 1'b1;
      expRxEr[RXS + 2 * j]      = rxErBit[j];
      expRxEr[RXS + 2 * j + 1]  = rxErBit[j];
    end

    applyStimulus(1'b0, 2'd0, 4'h0, 1'b0, 1'b0);
    resetDut();
    for (int e = 0; e < NC; e++) begin
      logic       txEn;
      logic [1:0] txd;
      txEn = (e >= TXS) && (e < TXS + txLen);
      txd  = txEn ? txDib[e - TXS] : 2'($urandom_range(0, 3));
      if (e >= RXS && e < RXS + 128)
        applyStimulus(txEn, txd, rxNib[(e - RXS) / 2], 1'b1, rxErBit[(e - RXS) / 2]);
      else
        applyStimulus(txEn, txd, 4'h0, 1'b0, 1'b0);
      mii_crs = 1'($urandom_range(0, 1));
      mii_col = 1'($urandom_range(0, 1));
      tick();
      checkOutput($sformatf("random%0d", e), outBus(),
                  packExp(expTxd[e], expTxEn[e], expRxd[e], expCrsDv[e], expRxEr[e]));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/rmii_mii.md
RMII_MII -- requirements
Module: rmii_mii

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 rmii_refclk  input  1  sole clock, 50 MHz; all logic SHALL be on its rising edge.
REQ-003 rst_l  input  1  asynchronous active-low reset.
REQ-004 rmii_txd  input  2  RMII transmit dibit from the MAC.
REQ-005 rmii_tx_en  input  1  RMII transmit enable from the MAC.
REQ-006 rmii_rxd  output  2  RMII receive dibit to the MAC.
REQ-007 rmii_crs_dv  output  1  RMII carrier-sense/data-valid to the MAC.
REQ-008 rmii_rx_er  output  1  RMII receive error to the MAC.
REQ-009 mii_rxclk, mii_txclk  input  1 each  pin compatibility only; SHALL NOT be used as clocks or logic inputs.
REQ-010 mii_rxd  input  4  MII receive nibble from the PHY-side block.
REQ-011 mii_rx_dv, mii_rx_er  input  1 each  MII receive valid and error.
REQ-012 mii_crs, mii_col  input  1 each  MII carrier and collision; SHALL be ignored.
REQ-013 mii_txd  output  4  MII transmit nibble to the PHY-side block.
REQ-014 mii_tx_en, mii_tx_er  output  1 each  MII transmit enable and error.

Function
REQ-015 The block SHALL support 100 Mb/s only: each MII nibble spans exactly 2 rmii_refclk cycles.
REQ-016 TX slot bit sel SHALL be 0 on any cycle where rmii_tx_en=0, SHALL toggle on every cycle where rmii_tx_en=1, and SHALL be frame-aligned: the first tx_en=1 cycle is slot 0.
REQ-017 On a slot-0 cycle, rmii_txd SHALL be stored as the low dibit.
REQ-018 On a slot-1 cycle (completion), the registered outputs SHALL load mii_txd={rmii_txd, stored low dibit} and mii_tx_en=1, and set hold=1.
REQ-019 On any non-completion cycle, hold SHALL clear; if hold was 0 and rmii_tx_en=0, the outputs SHALL load mii_tx_en=0 and mii_txd=0; otherwise the outputs SHALL be unchanged.
REQ-020 Each nibble SHALL be held exactly 2 cycles; first-dibit-to-mii_txd latency SHALL be 2 cycles.
REQ-021 A trailing odd dibit (tx_en falls after slot 0) SHALL be discarded, and mii_tx_en SHALL fall 2 cycles after the last completion.
REQ-022 mii_tx_er SHALL be constant 0.
REQ-023 RX phase bit ph SHALL be 0 after reset and SHALL toggle every cycle.
REQ-024 The upstream block SHALL hold mii_rxd, mii_rx_dv and mii_rx_er stable across each ph=0 sampling edge.
REQ-025 On a ph=0 cycle, the block SHALL register rmii_rxd<=mii_rxd[1:0], rmii_crs_dv<=mii_rx_dv and rmii_rx_er<=mii_rx_er, and store hi<=mii_rxd[3:2].
REQ-026 On a ph=1 cycle, the block SHALL register rmii_rxd<=hi; rmii_crs_dv and rmii_rx_er SHALL hold.
REQ-027 RX latency SHALL be 1 cycle from the sampling edge; dibit order SHALL be low then high.
REQ-028 TX and RX paths SHALL be fully independent; simultaneous traffic SHALL be supported.

Reset
REQ-029 While rst_l=0, all outputs, sel, hold, ph, hi and the stored low dibit SHALL be 0 immediately, with no clock required.
REQ-030 After rst_l rises, the first clock edge SHALL be ph=0; reset mid-frame SHALL drop the frame with no partial nibble emitted.

Verification
REQ-031 TX: tx_en=1 for 4 cycles with rmii_txd=1,2,3,0 -> mii_txd=0x9 for 2 cycles then 0x3 for 2 cycles, tx_en=1 throughout, then 0.
REQ-032 Odd TX: tx_en=1 for 3 cycles with rmii_txd=2,1,3 -> one nibble 0x6 (2 cycles), dibit 3 discarded, mii_tx_en falls.
REQ-033 RX: mii_rxd=0xB, rx_dv=1 held over a ph=0 edge -> rmii_rxd=3 then 2 on consecutive cycles, crs_dv=1.
REQ-034 RX error: rx_er=1, rx_dv=1 -> rmii_rx_er=1 for 2 cycles; mii_col and mii_crs toggling -> no output effect.
REQ-035 Reset asserted mid-TX and mid-RX -> all outputs 0 asynchronously; after release, ph restarts at 0.
REQ-036 Concurrent TX and RX frames of 64 nibbles -> both paths bit-exact with no interference.
